// File: rtl/speed_governor.sv
// rtl/speed_governor.sv - zone-limited speed governor with obstacle and failure-probability braking
// Optional build macro: SPEED_GOV_FAILSAFE_LATCH_EN (defined: FAILSAFE is left only by reset;
// undefined: FAILSAFE returns to RUN once stopped and fail_prob has dropped to the warning threshold).
module speed_governor #(
  parameter int SPEED_W      = 7,
  parameter int DIST_W       = 9,
  parameter int ZONE_W       = 4,
  parameter int ACCEL_STEP   = 1,
  parameter int DECEL_STEP   = 1,
  parameter int LIMIT_MARGIN = 10,
  parameter int WARN_THR     = 10,
  parameter int STOP_THR     = 50
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              throttle,
  input  logic              brake,
  input  logic [ZONE_W-1:0] zone,
  output logic [ZONE_W-1:0] lim_addr,
  input  logic [SPEED_W-1:0] lim_data,
  input  logic [6:0]        fail_prob,
  input  logic [DIST_W-1:0] stop_dist,
  input  logic [DIST_W-1:0] obs_dist,
  output logic [SPEED_W-1:0] speed,
  output logic [2:0]        state,
  output logic              failsafe
);

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_LOAD     = 3'd1,
    S_RUN      = 3'd2,
    S_LIM_WAIT = 3'd3,
    S_FAILSAFE = 3'd4
  } state_t;

  localparam logic [SPEED_W-1:0] ACC    = SPEED_W'(ACCEL_STEP);
  localparam logic [SPEED_W-1:0] DEC    = SPEED_W'(DECEL_STEP);
  localparam logic [SPEED_W-1:0] MARGIN = SPEED_W'(LIMIT_MARGIN);
  localparam logic [6:0]         WARN   = 7'(WARN_THR);
  localparam logic [6:0]         STOP   = 7'(STOP_THR);

  state_t             st;
  logic [SPEED_W-1:0] cur_lim;

  logic               stop_req;
  logic               warn_req;
  logic               obs_close;
  logic               over_lim;
  logic               zone_chg;
  logic [SPEED_W:0]   acc_sum;
  logic [SPEED_W-1:0] spd_dec;
  logic [SPEED_W-1:0] spd_acc;
  logic [SPEED_W-1:0] spd_run;
  logic [SPEED_W-1:0] spd_load;

  assign state = st;

  // Next-speed candidates and the RUN priority chain (limit, obstacle, warning, brake, throttle)
  always_comb begin
    stop_req  = fail_prob > STOP;
    warn_req  = fail_prob > WARN;
    obs_close = obs_dist < stop_dist;
    over_lim  = speed > cur_lim;
    zone_chg  = zone != lim_addr;
    spd_dec   = (speed < DEC) ? '0 : speed - DEC;
    acc_sum   = {1'b0, speed} + {1'b0, ACC};
    spd_acc   = (acc_sum > {1'b0, cur_lim}) ? cur_lim : acc_sum[SPEED_W-1:0];
    spd_load  = (lim_data < MARGIN) ? '0 : lim_data - MARGIN;
    if (over_lim || obs_close || warn_req || brake) begin
      spd_run = spd_dec;
    end else if (throttle) begin
      spd_run = spd_acc;
    end else begin
      spd_run = speed;
    end
  end

  // Governor FSM; every output is a flop updated here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= S_INIT;
      speed    <= '0;
      lim_addr <= '0;
      cur_lim  <= '0;
      failsafe <= 1'b0;
    end else begin
      case (st)
        S_INIT: begin
          lim_addr <= zone;
          st       <= S_LOAD;
        end
        S_LOAD: begin
          speed   <= spd_load;
          cur_lim <= lim_data;
          st      <= S_RUN;
        end
        S_RUN: begin
          if (stop_req) begin
            // Entering FAILSAFE already counts as the first braking cycle
            speed    <= spd_dec;
            failsafe <= 1'b1;
            st       <= S_FAILSAFE;
          end else begin
            speed <= spd_run;
            if (zone_chg) begin
              lim_addr <= zone;
              st       <= S_LIM_WAIT;
            end
          end
        end
        S_LIM_WAIT: begin
          // Limit is loaded even when escaping to FAILSAFE so cur_lim always matches lim_addr
          cur_lim <= lim_data;
          if (stop_req) begin
            speed    <= spd_dec;
            failsafe <= 1'b1;
            st       <= S_FAILSAFE;
          end else begin
            st <= S_RUN;
          end
        end
        S_FAILSAFE: begin
          speed <= spd_dec;
`ifdef SPEED_GOV_FAILSAFE_LATCH_EN
          st <= S_FAILSAFE;
`else
          if (speed == '0 && !warn_req) begin
            failsafe <= 1'b0;
            st       <= S_RUN;
          end
`endif
        end
        default: begin
          speed    <= '0;
          failsafe <= 1'b0;
          st       <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_speed_governor.sv
// tb/tb_speed_governor.sv - directed scoreboard bench for speed_governor
module tb_speed_governor;

  logic       clk;
  logic       rst_n;
  logic       throttle;
  logic       brake;
  logic [3:0] zone;
  logic [3:0] lim_addr;
  logic [6:0] lim_data;
  logic [6:0] fail_prob;
  logic [8:0] stop_dist;
  logic [8:0] obs_dist;
  logic [6:0] speed;
  logic [2:0] state;
  logic       failsafe;

  logic [6:0] lim_mem [16];

  typedef struct {
    string      tag;
    logic [6:0] spd;
    logic [2:0] st;
    logic       fs;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_mis;

  speed_governor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .throttle  (throttle),
    .brake     (brake),
    .zone      (zone),
    .lim_addr  (lim_addr),
    .lim_data  (lim_data),
    .fail_prob (fail_prob),
    .stop_dist (stop_dist),
    .obs_dist  (obs_dist),
    .speed     (speed),
    .state     (state),
    .failsafe  (failsafe)
  );

  assign lim_data = lim_mem[lim_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic push(input string tag, input int spd, input int st, input bit fs);
    exp_t e;
    e.tag = tag;
    e.spd = 7'(spd);
    e.st  = 3'(st);
    e.fs  = fs;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      assert (speed === e.spd) else begin
        n_mis++;
        $error("FAIL %s speed: got %0d expected %0d", e.tag, speed, e.spd);
      end
      n_cmp++;
      assert (state === e.st) else begin
        n_mis++;
        $error("FAIL %s state: got %0d expected %0d", e.tag, state, e.st);
      end
      n_cmp++;
      assert (failsafe === e.fs) else begin
        n_mis++;
        $error("FAIL %s failsafe: got %0b expected %0b", e.tag, failsafe, e.fs);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic check_la(input string tag, input logic [3:0] exp_la);
    n_cmp++;
    assert (lim_addr === exp_la) else begin
      n_mis++;
      $error("FAIL %s lim_addr: got %0d expected %0d", tag, lim_addr, exp_la);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    for (int i = 0; i < 16; i++) lim_mem[i] = 7'd100;
    lim_mem[0] = 7'd40;
    lim_mem[1] = 7'd25;
    rst_n     = 1'b0;
    throttle  = 1'b0;
    brake     = 1'b0;
    zone      = 4'd0;
    fail_prob = 7'd0;
    stop_dist = 9'd0;
    obs_dist  = 9'd100;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    push("reset", 0, 0, 0);
    drain();
    check_la("reset", 4'd0);

    // startup: INIT -> LOAD -> RUN with speed = 40 - 10
    rst_n = 1'b1;
    push("init", 0, 1, 0);
    tick();
    push("load", 30, 2, 0);
    tick();

    // throttle climbs to the limit and holds
    throttle = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      push("accel", (30 + i > 40) ? 40 : 30 + i, 2, 0);
      tick();
    end

    // brake beats throttle
    brake = 1'b1;
    push("brake_wins", 39, 2, 0);
    tick();
    brake    = 1'b0;
    throttle = 1'b0;
    push("hold", 39, 2, 0);
    tick();
    throttle = 1'b1;
    push("reaccel", 40, 2, 0);
    tick();

    // zone change to limit 25: one LIM_WAIT cycle then walk down, throttle ignored
    zone = 4'd1;
    push("zone_chg", 40, 3, 0);
    tick();
    check_la("zone_chg", 4'd1);
    push("lim_wait", 40, 2, 0);
    tick();
    for (int i = 1; i <= 15; i++) begin
      push("over_lim", 40 - i, 2, 0);
      tick();
    end
    push("at_lim", 25, 2, 0);
    tick();

    // brake down to 10
    throttle = 1'b0;
    brake    = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      push("brake_down", 25 - i, 2, 0);
      tick();
    end
    brake = 1'b0;

    // obstacle closer than stopping distance: down to 0 without underflow
    obs_dist  = 9'd20;
    stop_dist = 9'd60;
    for (int i = 1; i <= 10; i++) begin
      push("obstacle", 10 - i, 2, 0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      push("no_underflow", 0, 2, 0);
      tick();
    end
    obs_dist = 9'd100;

    // climb to 5, then threshold boundaries
    throttle = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      push("climb", i, 2, 0);
      tick();
    end
    fail_prob = 7'd10;
    push("warn_edge", 6, 2, 0);
    tick();
    fail_prob = 7'd50;
    throttle  = 1'b0;
    push("stop_edge", 5, 2, 0);
    tick();

    // failsafe: 5 cycles to 0, throttle ignored
    fail_prob = 7'd60;
    throttle  = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      push("failsafe", 5 - i, 4, 1);
      tick();
    end
    push("fs_hold", 0, 4, 1);
    tick();
    fail_prob = 7'd0;
    throttle  = 1'b0;
`ifdef SPEED_GOV_FAILSAFE_LATCH_EN
    push("fs_latched", 0, 4, 1);
    tick();
    push("fs_latched2", 0, 4, 1);
    tick();
`else
    push("fs_exit", 0, 2, 0);
    tick();
    push("fs_exit_hold", 0, 2, 0);
    tick();
`endif

    // reset out of any state re-runs INIT and LOAD
    zone  = 4'd0;
    rst_n = 1'b0;
    #2;
    push("reset2", 0, 0, 0);
    drain();
    check_la("reset2", 4'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push("init2", 0, 1, 0);
    tick();
    push("load2", 30, 2, 0);
    tick();

    // asynchronous reset mid-deceleration
    brake = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      push("decel", 30 - i, 2, 0);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    push("async_reset", 0, 0, 0);
    drain();
    brake = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push("init3", 0, 1, 0);
    tick();
    push("load3", 30, 2, 0);
    tick();
    check_la("load3", 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/speed_governor.md
SPEED_GOVERNOR -- requirements
Module: speed_governor

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- SPEED_W, 7, speed and limit width.
- DIST_W, 9, distance width.
- ZONE_W, 4, zone address width.
- ACCEL_STEP, 1, speed increase per throttle cycle.
- DECEL_STEP, 1, speed decrease per braking cycle.
- LIMIT_MARGIN, 10, initial offset below the zone limit.
- WARN_THR, 10, fail_prob warning threshold.
- STOP_THR, 50, fail_prob failsafe threshold.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- throttle, in, 1, accelerate request.
- brake, in, 1, decelerate request.
- zone, in, ZONE_W, current map zone {y,x}.
- lim_addr, out, ZONE_W, address to the external speed-limit memory.
- lim_data, in, SPEED_W, limit read data, valid one cycle after lim_addr changes.
- fail_prob, in, 7, failure probability in percent.
- stop_dist, in, DIST_W, required stopping distance.
- obs_dist, in, DIST_W, distance to the obstacle.
- speed, out, SPEED_W, governed speed.
- state, out, 3, FSM state code.
- failsafe, out, 1, high while in FAILSAFE.

Function
REQ-003 FSM states SHALL be: INIT=0, LOAD=1, RUN=2, LIM_WAIT=3, FAILSAFE=4.
REQ-004 INIT SHALL drive lim_addr=zone and go to LOAD the next cycle.
REQ-005 LOAD SHALL set speed = lim_data - LIMIT_MARGIN, saturated at 0, register lim_data as cur_lim, and go to RUN.
REQ-006 In RUN, a zone value different from lim_addr SHALL update lim_addr and go to LIM_WAIT.
REQ-007 LIM_WAIT SHALL hold speed for one cycle, then load cur_lim from lim_data and return to RUN.
REQ-008 RUN SHALL apply exactly one action per cycle, in strict priority order:
- (a) fail_prob > STOP_THR: go to FAILSAFE.
- (b) speed > cur_lim: decelerate.
- (c) obs_dist < stop_dist: decelerate.
- (d) fail_prob > WARN_THR: decelerate.
- (e) brake: decelerate.
- (f) throttle: accelerate.
- (g) otherwise: hold.
REQ-009 Decelerate SHALL set speed = speed - DECEL_STEP, saturated at 0.
REQ-010 Accelerate SHALL set speed = min(speed + ACCEL_STEP, cur_lim), with no overflow of SPEED_W.
REQ-011 When throttle and brake are both high, brake SHALL win.
REQ-012 FAILSAFE SHALL decelerate by DECEL_STEP each cycle to 0 and ignore throttle.
REQ-013 The FAILSAFE exit rule SHALL be set by REQ-019.
REQ-014 All outputs SHALL be registered, with one-cycle latency from input to speed.
REQ-015 Condition (a) SHALL also be checked in LIM_WAIT, with the same effect.

Reset
REQ-016 When rst_n=0 the block SHALL asynchronously set speed=0, state=INIT, lim_addr=0, cur_lim=0 and failsafe=0.
REQ-017 Reset mid-operation, including in FAILSAFE, SHALL abort immediately; the restart SHALL re-run INIT and LOAD.

Configuration
REQ-018 The macro SPEED_GOV_FAILSAFE_LATCH_EN SHALL select the FAILSAFE exit behaviour.
REQ-019 With SPEED_GOV_FAILSAFE_LATCH_EN defined, FAILSAFE SHALL be left only by reset.
REQ-020 Without it, FAILSAFE SHALL return to RUN once speed==0 and fail_prob <= WARN_THR, holding speed at 0.

Verification
REQ-021 Reset release, zone=0, lim_data=40 -> speed=30 two cycles after rst_n rises, then state=RUN.
REQ-022 throttle=1 for 15 cycles at speed=30, cur_lim=40 -> speed climbs to 40 and holds; simultaneous brake=1 -> speed 39 next cycle.
REQ-023 speed=40, zone changes to a zone with limit 25 -> one LIM_WAIT cycle, then speed falls 1 per cycle to 25, with throttle ignored until then.
REQ-024 obs_dist=20, stop_dist=60, speed=10 -> speed decrements each cycle to 0 and stays at 0 with no underflow.
REQ-025 fail_prob=60 at speed=5 -> failsafe=1, speed reaches 0 in 5 cycles. Then fail_prob=0: stays in FAILSAFE with the macro defined; returns to RUN without it.
REQ-026 rst_n pulsed low mid-deceleration -> speed=0 and state=INIT immediately, without waiting for a clock edge.
